// File: rtl/dec_cnt.sv
// Loadable countdown timer with valid/ready start-count load and a one-cycle done pulse.
// Optional periodic reload mode is built when DEC_CNT_RELOAD_EN is defined.
module dec_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_vld_i,
    input  logic [W-1:0] load_dat_i,
    output logic         load_rdy_o,
    input  logic         tick_i,
    input  logic         abort_i,
    output logic [W-1:0] cnt_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e       r_state;
    logic [W-1:0] r_cnt;
    logic         r_done;
`ifdef DEC_CNT_RELOAD_EN
    logic [W-1:0] r_reload;
`endif

    logic [W:0]   w_dec_full;
    logic [W-1:0] w_dec;
    logic         w_borrow;
    logic         w_load_acc;
    logic         w_last_tick;

    // Decrementer with its borrow kept visible for the sim-only check below.
    assign w_dec_full  = {1'b0, r_cnt} - {{W{1'b0}}, 1'b1};
    assign w_dec       = w_dec_full[W-1:0];
    assign w_borrow    = w_dec_full[W];

    assign load_rdy_o  = (r_state == StIdle) & ~rst;
    assign w_load_acc  = load_vld_i & load_rdy_o;
    assign w_last_tick = tick_i & (r_cnt == {{(W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_done   <= 1'b0;
`ifdef DEC_CNT_RELOAD_EN
            r_reload <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_load_acc) begin
                        if (load_dat_i != '0) begin
                            r_state  <= StRun;
                            r_cnt    <= load_dat_i;
`ifdef DEC_CNT_RELOAD_EN
                            r_reload <= load_dat_i;
`endif
                        end else begin
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                        end
                    end
                end
                StRun: begin
                    // Abort takes priority over a coincident final tick.
                    if (abort_i) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else if (w_last_tick) begin
                        r_done <= 1'b1;
`ifdef DEC_CNT_RELOAD_EN
                        r_cnt  <= r_reload;
`else
                        r_state <= StIdle;
                        r_cnt   <= '0;
`endif
                    end else if (tick_i) begin
                        r_cnt <= w_dec;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cnt_o  = r_cnt;
    assign busy_o = (r_state == StRun);
    assign done_o = r_done;

    // The count never reaches zero while running, so the decrementer never borrows.
    a_no_borrow : assert property (@(posedge clk) disable iff (rst)
        (r_state == StRun) |-> !w_borrow);

endmodule

// File: tb/tb_dec_cnt.sv
// Self-checking bench for dec_cnt: directed vector table, reload sequence and random vs model.
module tb_dec_cnt;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_vld_i = 1'b0;
    logic [W-1:0] load_dat_i = '0;
    logic         load_rdy_o;
    logic         tick_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [W-1:0] cnt_o;
    logic         busy_o;
    logic         done_o;

    int n_checks = 0;
    int n_fail   = 0;

    dec_cnt #(.W(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load_vld_i (load_vld_i),
        .load_dat_i (load_dat_i),
        .load_rdy_o (load_rdy_o),
        .tick_i     (tick_i),
        .abort_i    (abort_i),
        .cnt_o      (cnt_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] dat;
        logic         tick;
        logic         abort;
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input int d, input logic t,
                                input logic a, input int c, input logic b, input logic dn,
                                input logic rd);
        vec_t x;
        x.rst = r; x.vld = v; x.dat = W'(d); x.tick = t; x.abort = a;
        x.cnt = W'(c); x.busy = b; x.done = dn; x.rdy = rd;
        vecs.push_back(x);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic t,
                         input logic a);
        rst = r; load_vld_i = v; load_dat_i = d; tick_i = t; abort_i = a;
    endtask

    task automatic step_check(input int idx, input logic [W-1:0] c, input logic b,
                              input logic dn, input logic rd);
        @(posedge clk);
        #1;
        check("cnt", idx, int'(cnt_o), int'(c));
        check("busy", idx, int'(busy_o), int'(b));
        check("done", idx, int'(done_o), int'(dn));
        check("rdy", idx, int'(load_rdy_o), int'(rd));
    endtask

    // Reference model: remaining count, running flag, period and pending done.
    bit           m_run;
    int unsigned  m_left;
    int unsigned  m_period;
    bit           m_done;

    function automatic void model_edge(input logic r, input logic v, input int unsigned d,
                                       input logic t, input logic a);
        m_done = 0;
        if (r) begin
            m_run = 0; m_left = 0;
        end else if (!m_run) begin
            if (v) begin
                if (d == 0) m_done = 1;
                else begin m_run = 1; m_left = d; m_period = d; end
            end
        end else if (a) begin
            m_run = 0; m_left = 0;
        end else if (t) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1;
`ifdef DEC_CNT_RELOAD_EN
                m_left = m_period;
`else
                m_run = 0;
`endif
            end
        end
    endfunction

    initial begin
        // rst vld dat tick abort | cnt busy done rdy
        add(1, 0, 0, 0, 0,   0, 0, 0, 0);
`ifndef DEC_CNT_RELOAD_EN
        add(0, 1, 3, 1, 0,   3, 1, 0, 0);   // N=3, tick held
        add(0, 0, 0, 1, 0,   2, 1, 0, 0);
        add(0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 1, 1);
        add(0, 0, 0, 1, 0,   0, 0, 0, 1);
        add(0, 1, 0, 0, 0,   0, 0, 1, 1);   // N=0
        add(0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(0, 1, 5, 0, 0,   5, 1, 0, 0);   // N=5 with gapped ticks
        add(0, 0, 0, 1, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0, 0);
        add(0, 0, 0, 1, 0,   3, 1, 0, 0);
        add(0, 0, 0, 1, 0,   2, 1, 0, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0, 0);
        add(0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(0, 1, 2, 0, 0,   2, 1, 0, 0);   // abort beats final tick
        add(0, 0, 0, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 1,   0, 0, 0, 1);
        add(0, 0, 0, 1, 0,   0, 0, 0, 1);
        add(0, 1, 2, 0, 0,   2, 1, 0, 0);   // load while busy, then back-to-back
        add(0, 1, 4, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 1, 1);
        add(0, 1, 1, 1, 0,   1, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 1, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 1);
`endif
        add(0, 1, 7, 0, 1,   7, 1, 0, 0);   // abort ignored in IDLE
        add(0, 0, 0, 1, 0,   6, 1, 0, 0);
        add(1, 0, 0, 1, 0,   0, 0, 0, 0);   // reset mid-run
        add(0, 0, 0, 0, 0,   0, 0, 0, 1);
        add(0, 1, 255, 0, 0, 255, 1, 0, 0); // max count
        add(0, 0, 0, 1, 0, 254, 1, 0, 0);
        add(0, 0, 0, 0, 1,   0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].dat, vecs[i].tick, vecs[i].abort);
            step_check(i, vecs[i].cnt, vecs[i].busy, vecs[i].done, vecs[i].rdy);
        end

`ifdef DEC_CNT_RELOAD_EN
        // Periodic mode: N=2 repeats until abort; then reset mid-run.
        drive(0, 1, 2, 1, 0); step_check(100, 2, 1, 0, 0);
        drive(0, 0, 0, 1, 0); step_check(101, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0); step_check(102, 2, 1, 1, 0);
        drive(0, 0, 0, 1, 0); step_check(103, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0); step_check(104, 2, 1, 1, 0);
        drive(0, 0, 0, 1, 1); step_check(105, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0); step_check(106, 0, 0, 1, 1);
        drive(0, 1, 3, 1, 0); step_check(107, 3, 1, 0, 0);
        drive(0, 0, 0, 1, 0); step_check(108, 2, 1, 0, 0);
        drive(1, 0, 0, 1, 0); step_check(109, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0); step_check(110, 0, 0, 0, 1);
`endif

        // Random phase against the model, starting from reset.
        m_run = 0; m_left = 0; m_period = 0; m_done = 0;
        drive(1, 0, '0, 0, 0);
        model_edge(1, 0, 0, 0, 0);
        step_check(1000, W'(m_left), m_run, m_done, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            logic         r, v, t, a;
            logic [W-1:0] d;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            t = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 15) == 0);
            drive(r, v, d, t, a);
            model_edge(r, v, int'(d), t, a);
            step_check(2000 + i, W'(m_left), m_run, m_done, !m_run && !r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
